// File: rtl/kmkz_pipe_ctrl.sv
// kmkz_pipe_ctrl: pipeline stall/kill control, interrupt/NMI
// synchronisers and the RUN/HALT/WFI core state machine.
//
// Ports:
//   CLK, nRST       clock, async active-low reset
//   stall_req_i     per-stage stall requests (bit0 = fetch)
//   bra_i           branch taken at BRANCH_STAGE
//   trap_i, wfi_i   execute-stage trap / WFI retire
//   dbg_halt_i      debugger halt request
//   dbg_resume_i    debugger resume
//   nIRQ            async active-low interrupts
//   irq_mask_i      interrupt enables (1 = enabled)
//   nNMI            async active-low NMI
//   nmi_ack_i       clears the latched NMI
//   stall_o         per-stage stall (writeback never stalls)
//   kill_o          per-stage kill (squash wrong-path work)
//   irq_pending_o   synchronised, masked interrupts
//   nmi_pending_o   latched NMI
//   halted_o, wfi_o state decodes
module kmkz_pipe_ctrl #(
  parameter int N_STAGES     = 4,
  parameter int BRANCH_STAGE = 2,
  parameter int N_IRQ        = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [N_STAGES-1:0] stall_req_i,
  input  logic                bra_i,
  input  logic                trap_i,
  input  logic                wfi_i,
  input  logic                dbg_halt_i,
  input  logic                dbg_resume_i,
  input  logic [N_IRQ-1:0]    nIRQ,
  input  logic [N_IRQ-1:0]    irq_mask_i,
  input  logic                nNMI,
  input  logic                nmi_ack_i,
  output logic [N_STAGES-1:0] stall_o,
  output logic [N_STAGES-1:0] kill_o,
  output logic [N_IRQ-1:0]    irq_pending_o,
  output logic                nmi_pending_o,
  output logic                halted_o,
  output logic                wfi_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_WFI  = 2'b10
  } state_t;

  state_t                  r_state;
  logic [BRANCH_STAGE-1:0] r_bra_hist;
  logic [BRANCH_STAGE-1:0] w_hist_nxt;
  logic [N_IRQ-1:0]        r_sync_irq [SYNC_STAGES];
  logic [SYNC_STAGES-1:0]  r_sync_nmi;
  logic                    r_nmi_prev;
  logic [N_IRQ-1:0]        r_irq_pend;
  logic                    r_nmi_pend;
  logic [N_STAGES-1:0]     w_stall;
  logic [N_STAGES-1:0]     w_kill;
  logic                    w_not_run;
  logic                    w_nmi_s;
  logic                    w_nmi_edge;
  logic                    w_wake;
  logic                    w_unused;

  // Fetch's own request only stalls stages behind it, of
  // which there are none.
  assign w_unused  = stall_req_i[0];

  assign w_not_run = (r_state != ST_RUN);

  // A stage stalls when any younger-indexed (downstream)
  // stage requests, or the core is not running.
  always_comb begin
    w_stall = '0;
    for (int s = 0; s < N_STAGES-1; s++) begin
      w_stall[s] = w_not_run;
      for (int j = s+1; j < N_STAGES; j++) begin
        w_stall[s] = w_stall[s] | stall_req_i[j];
      end
    end
  end

  assign stall_o = w_stall;

  // Stage s is wrong-path while a taken branch is still
  // within s slots of it in the history.
  always_comb begin
    w_kill = '0;
    for (int s = 0; s <= BRANCH_STAGE; s++) begin
      w_kill[s] = bra_i;
      for (int k = 0; k < s; k++) begin
        w_kill[s] = w_kill[s] | r_bra_hist[k];
      end
    end
  end

  assign kill_o = w_kill;

  always_comb begin
    w_hist_nxt    = r_bra_hist << 1;
    w_hist_nxt[0] = bra_i;
  end

  // History advances only when the branch stage moves.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_bra_hist <= '0;
    end else if (!w_stall[BRANCH_STAGE]) begin
      r_bra_hist <= w_hist_nxt;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync_irq[k] <= '1;
      end
    end else begin
      r_sync_irq[0] <= nIRQ;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync_irq[k] <= r_sync_irq[k-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_irq_pend <= '0;
    end else begin
      r_irq_pend <= ~r_sync_irq[SYNC_STAGES-1]
                    & irq_mask_i;
    end
  end

  assign irq_pending_o = r_irq_pend;

  assign w_nmi_s    = r_sync_nmi[SYNC_STAGES-1];
  assign w_nmi_edge = r_nmi_prev & ~w_nmi_s;

  // Edge-triggered so a held-low NMI latches only once;
  // a new edge outranks a simultaneous acknowledge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sync_nmi <= '1;
      r_nmi_prev <= 1'b1;
      r_nmi_pend <= 1'b0;
    end else begin
      r_sync_nmi <= {r_sync_nmi[SYNC_STAGES-2:0], nNMI};
      r_nmi_prev <= w_nmi_s;
      if (w_nmi_edge) begin
        r_nmi_pend <= 1'b1;
      end else if (nmi_ack_i) begin
        r_nmi_pend <= 1'b0;
      end
    end
  end

  assign nmi_pending_o = r_nmi_pend;

  assign w_wake = (|r_irq_pend) | r_nmi_pend;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (trap_i | dbg_halt_i) begin
            r_state <= ST_HALT;
          end else if (wfi_i) begin
            r_state <= ST_WFI;
          end
        end
        ST_HALT: begin
          if (dbg_resume_i & ~dbg_halt_i) begin
            r_state <= ST_RUN;
          end
        end
        ST_WFI: begin
          if (dbg_halt_i) begin
            r_state <= ST_HALT;
          end else if (w_wake) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign halted_o = (r_state == ST_HALT);
  assign wfi_o    = (r_state == ST_WFI);

endmodule

// File: tb/tb_kmkz_pipe_ctrl.sv
// tb_kmkz_pipe_ctrl: directed and random checks of
// kmkz_pipe_ctrl against a queue-based reference model.
module tb_kmkz_pipe_ctrl;

  localparam int NS = 4;
  localparam int BS = 2;
  localparam int NI = 32;
  localparam int SS = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [NS-1:0] stall_req_i;
  logic          bra_i, trap_i, wfi_i;
  logic          dbg_halt_i, dbg_resume_i;
  logic [NI-1:0] nIRQ, irq_mask_i;
  logic          nNMI, nmi_ack_i;
  logic [NS-1:0] stall_o, kill_o;
  logic [NI-1:0] irq_pending_o;
  logic          nmi_pending_o, halted_o, wfi_o;

  kmkz_pipe_ctrl #(
    .N_STAGES(NS), .BRANCH_STAGE(BS),
    .N_IRQ(NI), .SYNC_STAGES(SS)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .stall_req_i(stall_req_i), .bra_i(bra_i),
    .trap_i(trap_i), .wfi_i(wfi_i),
    .dbg_halt_i(dbg_halt_i),
    .dbg_resume_i(dbg_resume_i),
    .nIRQ(nIRQ), .irq_mask_i(irq_mask_i),
    .nNMI(nNMI), .nmi_ack_i(nmi_ack_i),
    .stall_o(stall_o), .kill_o(kill_o),
    .irq_pending_o(irq_pending_o),
    .nmi_pending_o(nmi_pending_o),
    .halted_o(halted_o), .wfi_o(wfi_o)
  );

  always #5 CLK = ~CLK;

  int ntests = 0;
  int nfail  = 0;

  // Reference model: 0 = run, 1 = halt, 2 = wfi
  int            mst;
  bit            bq[$];
  logic [NI-1:0] irq_q[$];
  bit            nmi_q[$];
  logic [NI-1:0] m_irq;
  bit            m_nmi;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [NS-1:0] exp_stall();
    logic [NS-1:0] e;
    e = '0;
    for (int s = 0; s < NS-1; s++) begin
      e[s] = ((stall_req_i >> (s+1)) != 0) || (mst != 0);
    end
    return e;
  endfunction

  function automatic logic [NS-1:0] exp_kill();
    logic [NS-1:0] e;
    e = '0;
    for (int s = 0; s <= BS; s++) begin
      e[s] = bra_i;
      for (int k = 0; k < s; k++) e[s] = e[s] | bq[k];
    end
    return e;
  endfunction

  task automatic model_reset();
    mst = 0;
    bq.delete();
    repeat (BS) bq.push_back(1'b0);
    irq_q.delete();
    repeat (SS) irq_q.push_back('1);
    nmi_q.delete();
    repeat (SS+1) nmi_q.push_back(1'b1);
    m_irq = '0;
    m_nmi = 1'b0;
  endtask

  task automatic model_edge();
    int            nst;
    logic [NS-1:0] st;
    logic [NI-1:0] sy;
    bit            ns, np;
    nst = mst;
    case (mst)
      0: if (trap_i || dbg_halt_i) nst = 1;
         else if (wfi_i) nst = 2;
      1: if (dbg_resume_i && !dbg_halt_i) nst = 0;
      default:
         if (dbg_halt_i) nst = 1;
         else if (m_irq != 0 || m_nmi) nst = 0;
    endcase
    st = exp_stall();
    if (!st[BS]) begin
      bq.push_front(bra_i);
      void'(bq.pop_back());
    end
    sy = irq_q[SS-1];
    ns = nmi_q[SS-1];
    np = nmi_q[SS];
    m_irq = ~sy & irq_mask_i;
    if (np && !ns) m_nmi = 1'b1;
    else if (nmi_ack_i) m_nmi = 1'b0;
    irq_q.push_front(nIRQ);
    void'(irq_q.pop_back());
    nmi_q.push_front(nNMI);
    void'(nmi_q.pop_back());
    mst = nst;
  endtask

  task automatic tick();
    if (!nRST) model_reset();
    else model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all();
    chk("stall", 32'(stall_o), 32'(exp_stall()));
    chk("kill", 32'(kill_o), 32'(exp_kill()));
    chk("irq_pend", irq_pending_o, m_irq);
    chk("nmi_pend", 32'(nmi_pending_o), 32'(m_nmi));
    chk("halted", 32'(halted_o), 32'(mst == 1));
    chk("wfi", 32'(wfi_o), 32'(mst == 2));
  endtask

  initial begin
    nRST = 1'b0;
    stall_req_i = '0;
    bra_i = 0; trap_i = 0; wfi_i = 0;
    dbg_halt_i = 0; dbg_resume_i = 0;
    nIRQ = '1; irq_mask_i = '0;
    nNMI = 1'b1; nmi_ack_i = 1'b0;
    model_reset();
    #1;
    chk("rst_halted", 32'(halted_o), 0);
    chk("rst_wfi", 32'(wfi_o), 0);
    chk("rst_irq", irq_pending_o, 0);
    check_all();
    tick(); tick();
    nRST = 1'b1;
    #1 check_all();

    // Single unstalled branch
    bra_i = 1;
    #1 chk("kill_c0", 32'(kill_o), 32'b0111);
    tick(); bra_i = 0;
    #1 chk("kill_c1", 32'(kill_o), 32'b0110);
    tick();
    #1 chk("kill_c2", 32'(kill_o), 32'b0100);
    tick();
    #1 chk("kill_c3", 32'(kill_o), 32'b0000);

    // Branch held by a writeback stall
    bra_i = 1;
    #1 check_all();
    tick(); bra_i = 0; stall_req_i = 4'b1000;
    repeat (3) begin
      #1;
      chk("stall_hold", 32'(stall_o), 32'b0111);
      chk("kill_hold", 32'(kill_o[2:1]), 32'b11);
      check_all();
      tick();
    end
    stall_req_i = '0;
    repeat (3) begin #1 check_all(); tick(); end

    // WFI entry, masked IRQ, then unmasked wake
    wfi_i = 1;
    #1 check_all();
    tick(); wfi_i = 0;
    #1 chk("wfi_enter", 32'(wfi_o), 1);
    chk("wfi_stall", 32'(stall_o), 32'b0111);
    nIRQ[5] = 1'b0;
    repeat (8) begin #1 check_all(); tick(); end
    #1 chk("wfi_masked", 32'(wfi_o), 1);
    nIRQ = '1;
    repeat (3) tick();
    nIRQ[5] = 1'b0; irq_mask_i[5] = 1'b1;
    tick(); tick();
    #1 chk("irq_early", 32'(irq_pending_o[5]), 0);
    tick();
    #1 chk("irq_lat3", 32'(irq_pending_o[5]), 1);
    chk("wfi_still", 32'(wfi_o), 1);
    tick();
    #1 chk("wfi_wake", 32'(wfi_o), 0);
    check_all();
    nIRQ = '1; irq_mask_i = '0;
    repeat (3) begin #1 check_all(); tick(); end

    // Trap beats WFI; NMI does not leave HALT
    trap_i = 1; wfi_i = 1;
    #1 check_all();
    tick(); trap_i = 0; wfi_i = 0;
    #1 chk("prio_halt", 32'(halted_o), 1);
    nNMI = 1'b0;
    repeat (5) begin #1 check_all(); tick(); end
    #1 chk("halt_nmi", 32'(nmi_pending_o), 1);
    chk("halt_stay", 32'(halted_o), 1);
    dbg_resume_i = 1; dbg_halt_i = 1;
    tick();
    #1 chk("res_and_halt", 32'(halted_o), 1);
    dbg_halt_i = 0;
    tick(); dbg_resume_i = 0;
    #1 chk("resume", 32'(halted_o), 0);
    check_all();
    nmi_ack_i = 1;
    tick(); nmi_ack_i = 0;
    #1 chk("nmi_ack", 32'(nmi_pending_o), 0);

    // Held-low NMI sets once
    nNMI = 1'b1;
    repeat (3) tick();
    nNMI = 1'b0;
    repeat (3) tick();
    #1 chk("nmi_set", 32'(nmi_pending_o), 1);
    nmi_ack_i = 1;
    tick(); nmi_ack_i = 0;
    repeat (7) begin
      #1 chk("nmi_once", 32'(nmi_pending_o), 0);
      check_all();
      tick();
    end
    nNMI = 1'b1;
    repeat (3) tick();
    nNMI = 1'b0;
    tick(); tick();
    nmi_ack_i = 1;
    tick(); nmi_ack_i = 0;
    #1 chk("nmi_set_wins", 32'(nmi_pending_o), 1);
    nmi_ack_i = 1; nNMI = 1'b1;
    tick(); nmi_ack_i = 0;
    #1 check_all();

    // Asynchronous reset while in WFI with IRQ pending
    nIRQ[5] = 1'b0; irq_mask_i[5] = 1'b1;
    repeat (3) tick();
    wfi_i = 1;
    tick(); wfi_i = 0;
    #1 chk("pre_rst_wfi", 32'(wfi_o), 1);
    chk("pre_rst_irq", 32'(irq_pending_o != 0), 1);
    nRST = 1'b0;
    model_reset();
    #1 chk("rst_wfi_o", 32'(wfi_o), 0);
    chk("rst_irq_o", irq_pending_o, 0);
    check_all();
    tick();
    nRST = 1'b1; nIRQ = '1; irq_mask_i = '0;
    #1 check_all();
    tick();
    #1 check_all();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        nRST = 1'b0;
        model_reset();
      end else begin
        nRST = 1'b1;
      end
      stall_req_i  = NS'($urandom & $urandom);
      bra_i        = ($urandom_range(0, 2) == 0);
      trap_i       = ($urandom_range(0, 29) == 0);
      wfi_i        = ($urandom_range(0, 9) == 0);
      dbg_halt_i   = ($urandom_range(0, 19) == 0);
      dbg_resume_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0)
        nIRQ = $urandom | $urandom | $urandom;
      irq_mask_i   = $urandom;
      if ($urandom_range(0, 7) == 0) nNMI = ~nNMI;
      nmi_ack_i    = ($urandom_range(0, 5) == 0);
      #1 check_all();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

endmodule
